// File: rtl/mct_sequencer.sv
// MCT sequencer: frames memory cycle times from tp1..tp10 pulses and
// issues registered control strobes for one- and two-MCT subinstructions.
module mct_sequencer #(
  parameter int CNT_W = 16,
  parameter int RD_TP = 2,
  parameter int WR_TP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       tp,
  input  logic             inst_valid,
  input  logic [2:0]       inst_op,
  output logic             inst_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             a_rd,
  output logic             a_wr,
  output logic             b_wr,
  output logic             alu_add,
  output logic             done,
  output logic             illegal_op,
  output logic             seq_err,
  output logic [CNT_W-1:0] mct_count
);

  typedef enum logic [1:0] {
    IDLE,
    MCT1,
    MCT2
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_XCH   = 3'd4;

  state_t     r_state;
  logic [2:0] r_op;
  logic [9:0] r_last;

  logic       w_any;
  logic       w_multi;
  logic [9:0] w_succ;
  logic       w_err;
  logic       w_ok;
  logic       w_m1;
  logic       w_m2;
  logic       w_ld;
  logic       w_st;
  logic       w_add;
  logic       w_xch;
  logic       w_two;
  logic       w_acc;

  // r_last is zero until the first pulse, which disables the successor check
  assign w_any   = |tp;
  assign w_multi = (tp & (tp - 10'd1)) != 10'd0;
  assign w_succ  = {r_last[8:0], r_last[9]};
  assign w_err   = w_multi ||
                   (w_any && (r_last != 10'd0) && (tp != w_succ));
  assign w_ok    = w_any && !w_err;

  assign w_m1  = w_ok && (r_state == MCT1);
  assign w_m2  = w_ok && (r_state == MCT2);
  assign w_ld  = r_op == OP_LOAD;
  assign w_st  = r_op == OP_STORE;
  assign w_add = r_op == OP_ADD;
  assign w_xch = r_op == OP_XCH;
  assign w_two = w_add || w_xch;
  assign w_acc = w_ok && tp[0] && (r_state == IDLE) &&
                 inst_ready && inst_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= 3'd0;
      r_last     <= 10'd0;
      inst_ready <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      a_rd       <= 1'b0;
      a_wr       <= 1'b0;
      b_wr       <= 1'b0;
      alu_add    <= 1'b0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
      seq_err    <= 1'b0;
      mct_count  <= '0;
    end else begin
      mem_rd  <= w_m1 && tp[RD_TP-1] && (w_ld || w_two);
      mem_wr  <= tp[WR_TP-1] && ((w_m1 && w_st) || (w_m2 && w_xch));
      a_rd    <= tp[2] && ((w_m1 && w_st) || (w_m2 && w_xch));
      a_wr    <= (w_m1 && w_ld && tp[5]) ||
                 (w_m2 && w_add && tp[6]) ||
                 (w_m2 && w_xch && tp[8]);
      b_wr    <= w_m1 && w_two && tp[5];
      alu_add <= w_m2 && w_add && tp[3];

      done       <= 1'b0;
      illegal_op <= 1'b0;
      inst_ready <= r_state == IDLE;

      if (w_any) begin
        r_last <= w_multi ? 10'd0 : tp;
      end

      if (w_err) begin
        seq_err    <= 1'b1;
        r_state    <= IDLE;
        inst_ready <= 1'b1;
      end else if (w_ok && tp[9]) begin
        mct_count <= mct_count + 1'b1;
        unique case (r_state)
          MCT1: begin
            if (w_two) begin
              r_state <= MCT2;
            end else begin
              r_state    <= IDLE;
              done       <= 1'b1;
              inst_ready <= 1'b1;
            end
          end
          MCT2: begin
            r_state    <= IDLE;
            done       <= 1'b1;
            inst_ready <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_acc) begin
        r_op       <= inst_op;
        r_state    <= MCT1;
        inst_ready <= 1'b0;
        illegal_op <= inst_op > OP_XCH;
      end
    end
  end

endmodule
